id_stage_pipe: RTL and testbench

- Parametrised decode stage for the 5-stage MIPS pipeline: instruction decode, register file, branch/jump resolution in ID, and an owned ID/EX pipeline register.
- Adds in-stage hazard detection (load-use and branch-on-pending-result stalls), MEM/WB forwarding for branch compare, and write-first register bypass.
- Sits between the IF/ID register and the EX stage. Drives PC redirect, IF/ID stall and flush.

---
 rtl/id_pkg.sv | 101 ++++++++++
 rtl/id_regfile.sv | 57 +++++
 rtl/id_stage_pipe.sv | 183 ++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcode/funct values, ALU
// control encodings, the control bundle carried into ID/EX, and the decoder.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Control bundle as it travels into EX (field order is the ID/EX order).
    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       memread;
        logic       alusrc;
        logic       regdst;
        logic [3:0] aluctl;
    } ctrl_t;

    // Full decode result: EX control plus flags only the ID stage needs.
    typedef struct packed {
        ctrl_t ctrl;
        logic  uses_rt;
        logic  is_beq;
        logic  is_bne;
        logic  is_j;
    } dec_t;

    // Anything outside the supported set comes back as an all-zero NOP.
    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        logic ok;
        d  = '0;
        ok = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD:  d.ctrl.aluctl = ALU_ADD;
                    FN_SUB:  d.ctrl.aluctl = ALU_SUB;
                    FN_AND:  d.ctrl.aluctl = ALU_AND;
                    FN_OR:   d.ctrl.aluctl = ALU_OR;
                    FN_SLT:  d.ctrl.aluctl = ALU_SLT;
                    default: ok = 1'b0;
                endcase
                if (ok) begin
                    d.ctrl.regwrite = 1'b1;
                    d.ctrl.regdst   = 1'b1;
                    d.uses_rt       = 1'b1;
                end
            end
            OP_LW: begin
                d.ctrl.regwrite = 1'b1;
                d.ctrl.memtoreg = 1'b1;
                d.ctrl.memread  = 1'b1;
                d.ctrl.alusrc   = 1'b1;
                d.ctrl.aluctl   = ALU_ADD;
            end
            OP_SW: begin
                d.ctrl.memwrite = 1'b1;
                d.ctrl.alusrc   = 1'b1;
                d.ctrl.aluctl   = ALU_ADD;
                d.uses_rt       = 1'b1;
            end
            OP_BEQ: begin
                d.ctrl.aluctl = ALU_SUB;
                d.uses_rt     = 1'b1;
                d.is_beq      = 1'b1;
            end
            OP_BNE: begin
                d.ctrl.aluctl = ALU_SUB;
                d.uses_rt     = 1'b1;
                d.is_bne      = 1'b1;
            end
            OP_ADDI: begin
                d.ctrl.regwrite = 1'b1;
                d.ctrl.alusrc   = 1'b1;
                d.ctrl.aluctl   = ALU_ADD;
            end
            OP_J:    d.is_j = 1'b1;
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// NREGS x WIDTH register file, two async read ports, one write port.
// $0 and addresses beyond NREGS read as zero and are never written.
module id_regfile
    import id_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NREGS     = 32,
    parameter int RA_W      = 5,
    parameter int WB_BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  ra1,
    input  logic [RA_W-1:0]  ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             we,
    input  logic [RA_W-1:0]  wa,
    input  logic [WIDTH-1:0] wd
);

    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
    logic                        ra1_ok, ra2_ok, wa_ok;

    assign ra1_ok = (ra1 != '0) && (32'(ra1) < NREGS);
    assign ra2_ok = (ra2 != '0) && (32'(ra2) < NREGS);
    assign wa_ok  = we && (wa != '0) && (32'(wa) < NREGS);

    // Next register state: a single write per cycle.
    always_comb begin
        regs_d = regs_q;
        if (wa_ok) regs_d[wa[IW-1:0]] = wd;
    end

    // Register storage, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) regs_q <= '0;
        else     regs_q <= regs_d;
    end

    // Read ports; with bypass enabled a same-cycle write wins over storage.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1_ok) begin
            if ((WB_BYPASS != 0) && wa_ok && (wa == ra1)) rd1 = wd;
            else                                          rd1 = regs_q[ra1[IW-1:0]];
        end
        if (ra2_ok) begin
            if ((WB_BYPASS != 0) && wa_ok && (wa == ra2)) rd2 = wd;
            else                                          rd2 = regs_q[ra2[IW-1:0]];
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS ID stage: decode, register read, branch/jump resolution with MEM/WB
// forwarding for the compare, load-use and branch hazard stalls, and the
// ID/EX pipeline register.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NREGS     = 32,
    parameter int RA_W      = 5,
    parameter int WB_BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_instr,
    input  logic [WIDTH-1:0] id_pc,
    input  logic             id_valid,
    input  logic             wb_we,
    input  logic [RA_W-1:0]  wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             mem_we,
    input  logic             mem_memread,
    input  logic [RA_W-1:0]  mem_addr,
    input  logic [WIDTH-1:0] mem_alu,
    output logic             stall_if,
    output logic             flush_if,
    output logic             pcsrc,
    output logic [WIDTH-1:0] pc_target,
    output logic             ex_valid,
    output logic             ex_regwrite,
    output logic             ex_memtoreg,
    output logic             ex_memwrite,
    output logic             ex_memread,
    output logic             ex_alusrc,
    output logic             ex_regdst,
    output logic [3:0]       ex_aluctl,
    output logic [WIDTH-1:0] ex_data1,
    output logic [WIDTH-1:0] ex_data2,
    output logic [WIDTH-1:0] ex_imm,
    output logic [RA_W-1:0]  ex_rs,
    output logic [RA_W-1:0]  ex_rt,
    output logic [RA_W-1:0]  ex_rd
);

    // Instruction fields
    logic [5:0]       op, fn;
    logic [RA_W-1:0]  rs_a, rt_a, rd_a;
    logic [WIDTH-1:0] imm_sx;
    dec_t             dec;

    assign op     = id_instr[31:26];
    assign fn     = id_instr[5:0];
    assign rs_a   = RA_W'(id_instr[25:21]);
    assign rt_a   = RA_W'(id_instr[20:16]);
    assign rd_a   = RA_W'(id_instr[15:11]);
    assign imm_sx = {{(WIDTH-16){id_instr[15]}}, id_instr[15:0]};
    assign dec    = decode(op, fn);

    // ID/EX state
    logic             ex_valid_q, ex_valid_d;
    ctrl_t            ex_ctrl_q, ex_ctrl_d;
    logic [WIDTH-1:0] ex_data1_q, ex_data1_d, ex_data2_q, ex_data2_d;
    logic [WIDTH-1:0] ex_imm_q, ex_imm_d;
    logic [RA_W-1:0]  ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;

    // Register file
    logic [WIDTH-1:0] rf_rd1, rf_rd2;

    id_regfile #(
        .WIDTH(WIDTH), .NREGS(NREGS), .RA_W(RA_W), .WB_BYPASS(WB_BYPASS)
    ) u_rf (
        .clk(clk), .rst(rst),
        .ra1(rs_a), .ra2(rt_a), .rd1(rf_rd1), .rd2(rf_rd2),
        .we(wb_we), .wa(wb_addr), .wd(wb_data)
    );

    // Branch compare operands: MEM ALU result, then WB data, then the file.
    // The WB path is explicit so the compare sees it even without bypass.
    logic             rs_ok, rt_ok;
    logic [WIDTH-1:0] bop_a, bop_b;

    assign rs_ok = (rs_a != '0) && (32'(rs_a) < NREGS);
    assign rt_ok = (rt_a != '0) && (32'(rt_a) < NREGS);

    always_comb begin
        if (rs_ok && mem_we && !mem_memread && (mem_addr == rs_a)) bop_a = mem_alu;
        else if (rs_ok && wb_we && (wb_addr == rs_a))             bop_a = wb_data;
        else                                                      bop_a = rf_rd1;
        if (rt_ok && mem_we && !mem_memread && (mem_addr == rt_a)) bop_b = mem_alu;
        else if (rt_ok && wb_we && (wb_addr == rt_a))             bop_b = wb_data;
        else                                                      bop_b = rf_rd2;
    end

    // Hazard detection: load-use against EX, and branch operands still in
    // flight (any EX writer, or a load sitting in MEM).
    logic            is_br, load_use, br_haz, stall, taken, redirect;
    logic [RA_W-1:0] ex_dest;

    always_comb begin
        is_br    = dec.is_beq | dec.is_bne;
        ex_dest  = ex_ctrl_q.regdst ? ex_rd_q : ex_rt_q;
        load_use = ex_valid_q && ex_ctrl_q.memread && (ex_rt_q != '0) &&
                   ((ex_rt_q == rs_a) || (dec.uses_rt && (ex_rt_q == rt_a)));
        br_haz   = is_br &&
                   ((ex_valid_q && ex_ctrl_q.regwrite && (ex_dest != '0) &&
                     ((ex_dest == rs_a) || (ex_dest == rt_a))) ||
                    (mem_memread && (mem_addr != '0) &&
                     ((mem_addr == rs_a) || (mem_addr == rt_a))));
        stall    = !rst && id_valid && (load_use || br_haz);
        taken    = (dec.is_beq && (bop_a == bop_b)) || (dec.is_bne && (bop_a != bop_b));
        redirect = !rst && id_valid && !stall && (taken || dec.is_j);
    end

    assign stall_if = stall;
    assign pcsrc    = redirect;
    assign flush_if = redirect;

    // Redirect target: jump region splice or PC-relative branch.
    always_comb begin
        if (dec.is_j) pc_target = {id_pc[WIDTH-1:28], id_instr[25:0], 2'b00};
        else          pc_target = id_pc + (imm_sx << 2);
    end

    // ID/EX next state: decoded instruction, or a bubble on stall / empty slot.
    always_comb begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = '0;
        ex_data1_d = '0;
        ex_data2_d = '0;
        ex_imm_d   = '0;
        ex_rs_d    = '0;
        ex_rt_d    = '0;
        ex_rd_d    = '0;
        if (id_valid && !stall) begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = dec.ctrl;
            ex_data1_d = rf_rd1;
            ex_data2_d = rf_rd2;
            ex_imm_d   = imm_sx;
            ex_rs_d    = rs_a;
            ex_rt_d    = rt_a;
            ex_rd_d    = rd_a;
        end
    end

    // ID/EX register
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_data1_q <= '0;
            ex_data2_q <= '0;
            ex_imm_q   <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_data1_q <= ex_data1_d;
            ex_data2_q <= ex_data2_d;
            ex_imm_q   <= ex_imm_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_rd_q    <= ex_rd_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_regwrite = ex_ctrl_q.regwrite;
    assign ex_memtoreg = ex_ctrl_q.memtoreg;
    assign ex_memwrite = ex_ctrl_q.memwrite;
    assign ex_memread  = ex_ctrl_q.memread;
    assign ex_alusrc   = ex_ctrl_q.alusrc;
    assign ex_regdst   = ex_ctrl_q.regdst;
    assign ex_aluctl   = ex_ctrl_q.aluctl;
    assign ex_data1    = ex_data1_q;
    assign ex_data2    = ex_data2_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rs       = ex_rs_q;
    assign ex_rt       = ex_rt_q;
    assign ex_rd       = ex_rd_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe. A second instance with read-old register
// file behaviour shares all inputs to contrast the bypass setting.
module tb_id_stage_pipe;
    import id_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_instr, id_pc, wb_data, mem_alu;
    logic        id_valid, wb_we, mem_we, mem_memread;
    logic [4:0]  wb_addr, mem_addr;

    logic        stall_if, flush_if, pcsrc;
    logic [31:0] pc_target, ex_data1, ex_data2, ex_imm;
    logic        ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_memread, ex_alusrc, ex_regdst;
    logic [3:0]  ex_aluctl;
    logic [4:0]  ex_rs, ex_rt, ex_rd;

    logic        b_stall_if, b_flush_if, b_pcsrc;
    logic [31:0] b_pc_target, b_ex_data1, b_ex_data2, b_ex_imm;
    logic        b_ex_valid, b_ex_regwrite, b_ex_memtoreg, b_ex_memwrite, b_ex_memread, b_ex_alusrc, b_ex_regdst;
    logic [3:0]  b_ex_aluctl;
    logic [4:0]  b_ex_rs, b_ex_rt, b_ex_rd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.WIDTH(32), .NREGS(32), .RA_W(5), .WB_BYPASS(1)) dut (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_we(mem_we), .mem_memread(mem_memread), .mem_addr(mem_addr), .mem_alu(mem_alu),
        .stall_if(stall_if), .flush_if(flush_if), .pcsrc(pcsrc), .pc_target(pc_target),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
        .ex_memwrite(ex_memwrite), .ex_memread(ex_memread), .ex_alusrc(ex_alusrc),
        .ex_regdst(ex_regdst), .ex_aluctl(ex_aluctl), .ex_data1(ex_data1), .ex_data2(ex_data2),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd)
    );

    id_stage_pipe #(.WIDTH(32), .NREGS(32), .RA_W(5), .WB_BYPASS(0)) dut_old (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_we(mem_we), .mem_memread(mem_memread), .mem_addr(mem_addr), .mem_alu(mem_alu),
        .stall_if(b_stall_if), .flush_if(b_flush_if), .pcsrc(b_pcsrc), .pc_target(b_pc_target),
        .ex_valid(b_ex_valid), .ex_regwrite(b_ex_regwrite), .ex_memtoreg(b_ex_memtoreg),
        .ex_memwrite(b_ex_memwrite), .ex_memread(b_ex_memread), .ex_alusrc(b_ex_alusrc),
        .ex_regdst(b_ex_regdst), .ex_aluctl(b_ex_aluctl), .ex_data1(b_ex_data1), .ex_data2(b_ex_data2),
        .ex_imm(b_ex_imm), .ex_rs(b_ex_rs), .ex_rt(b_ex_rt), .ex_rd(b_ex_rd)
    );

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_ins(input logic [25:0] t);
        return {OP_J, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_instr = '0; id_pc = '0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        mem_we = 1'b0; mem_memread = 1'b0; mem_addr = '0; mem_alu = '0;
    endtask

    task automatic test_reset();
        idle();
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h55; tick();
        wb_we = 1'b0;
        id_valid = 1'b1; id_instr = i_ins(OP_LW, 5'd0, 5'd2, 16'h0008); tick();
        id_instr = r_ins(5'd2, 5'd1, 5'd5, FN_ADD); #1;
        n_tests++; if (stall_if !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall: got %0b want 1", stall_if); end
        rst = 1'b1; #1;
        n_tests++; if ({stall_if, pcsrc, flush_if} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_stall: got %b want 000", {stall_if, pcsrc, flush_if}); end
        id_instr = j_ins(26'h40); #1;
        n_tests++; if ({stall_if, pcsrc, flush_if} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_redirect: got %b want 000", {stall_if, pcsrc, flush_if}); end
        tick(); tick();
        n_tests++;
        if ({ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_memread, ex_alusrc, ex_regdst,
             ex_aluctl, ex_data1, ex_data2, ex_imm, ex_rs, ex_rt, ex_rd} !== '0) begin
            n_fail++; $display("FAIL rst_ex_zero: ex_valid=%0b memread=%0b data1=%h imm=%h rt=%0d want all 0",
                               ex_valid, ex_memread, ex_data1, ex_imm, ex_rt);
        end
        rst = 1'b0;
        id_instr = r_ins(5'd5, 5'd0, 5'd6, FN_ADD); tick();
        n_tests++; if ({ex_valid, ex_data1} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL rst_rf_clear: valid=%0b data1=%h want 1/00000000", ex_valid, ex_data1); end
    endtask

    task automatic test_write_first();
        idle();
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h1111; tick();
        id_valid = 1'b1; id_instr = r_ins(5'd3, 5'd0, 5'd4, FN_ADD); wb_data = 32'hDEAD; tick();
        wb_we = 1'b0;
        n_tests++; if (ex_data1 !== 32'hDEAD) begin n_fail++; $display("FAIL wf_bypass: got %h want 0000dead", ex_data1); end
        n_tests++; if (b_ex_data1 !== 32'h1111) begin n_fail++; $display("FAIL wf_readold: got %h want 00001111", b_ex_data1); end
        n_tests++; if ({ex_rs, ex_rd, ex_regdst, ex_regwrite, ex_aluctl} !== {5'd3, 5'd4, 1'b1, 1'b1, ALU_ADD}) begin
            n_fail++; $display("FAIL wf_fields: rs=%0d rd=%0d regdst=%0b regwrite=%0b alu=%b want 3/4/1/1/0010",
                               ex_rs, ex_rd, ex_regdst, ex_regwrite, ex_aluctl);
        end
        tick();
        n_tests++; if (b_ex_data1 !== 32'hDEAD) begin n_fail++; $display("FAIL wf_readold_after: got %h want 0000dead", b_ex_data1); end
    endtask

    task automatic test_load_use();
        idle(); tick();
        id_valid = 1'b1; id_instr = i_ins(OP_LW, 5'd0, 5'd2, 16'h0008); tick();
        n_tests++; if ({ex_valid, ex_regwrite, ex_memtoreg, ex_memread, ex_alusrc, ex_regdst, ex_rt, ex_imm} !== {6'b111110, 5'd2, 32'h8}) begin
            n_fail++; $display("FAIL lu_lw_decode: ctl=%b rt=%0d imm=%h want 111110/2/00000008",
                               {ex_valid, ex_regwrite, ex_memtoreg, ex_memread, ex_alusrc, ex_regdst}, ex_rt, ex_imm);
        end
        id_instr = r_ins(5'd2, 5'd1, 5'd5, FN_ADD); #1;
        n_tests++; if ({stall_if, pcsrc, flush_if} !== 3'b100) begin n_fail++; $display("FAIL lu_stall: got %b want 100", {stall_if, pcsrc, flush_if}); end
        tick();
        n_tests++; if ({ex_valid, ex_regwrite, stall_if} !== 3'b000) begin n_fail++; $display("FAIL lu_bubble: valid/regwrite/stall=%b want 000", {ex_valid, ex_regwrite, stall_if}); end
        tick();
        n_tests++; if ({ex_valid, ex_rs, ex_rd} !== {1'b1, 5'd2, 5'd5}) begin n_fail++; $display("FAIL lu_release: valid=%0b rs=%0d rd=%0d want 1/2/5", ex_valid, ex_rs, ex_rd); end
        id_instr = i_ins(OP_LW, 5'd0, 5'd2, 16'h0000); tick();
        id_instr = i_ins(OP_ADDI, 5'd3, 5'd2, 16'h0001); #1;
        n_tests++; if (stall_if !== 1'b0) begin n_fail++; $display("FAIL lu_rt_not_read: got %0b want 0", stall_if); end
    endtask

    task automatic test_branch_fwd();
        idle();
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd7; tick();
        wb_addr = 5'd2; wb_data = 32'd9; tick();
        wb_we = 1'b0;
        id_valid = 1'b1; id_pc = 32'h100; id_instr = i_ins(OP_BEQ, 5'd1, 5'd2, 16'h0004);
        mem_we = 1'b1; mem_memread = 1'b0; mem_addr = 5'd1; mem_alu = 32'd9; #1;
        n_tests++; if ({stall_if, pcsrc, flush_if} !== 3'b011) begin n_fail++; $display("FAIL bf_mem_taken: got %b want 011", {stall_if, pcsrc, flush_if}); end
        n_tests++; if (pc_target !== 32'h110) begin n_fail++; $display("FAIL bf_target: got %h want 00000110", pc_target); end
        mem_we = 1'b0; #1;
        n_tests++; if (pcsrc !== 1'b0) begin n_fail++; $display("FAIL bf_rf_not_taken: got %0b want 0", pcsrc); end
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd9; #1;
        n_tests++; if (pcsrc !== 1'b1) begin n_fail++; $display("FAIL bf_wb_taken: got %0b want 1", pcsrc); end
        mem_we = 1'b1; mem_alu = 32'd7; #1;
        n_tests++; if (pcsrc !== 1'b0) begin n_fail++; $display("FAIL bf_mem_over_wb: got %0b want 0", pcsrc); end
        idle();
    endtask

    task automatic test_branch_stall();
        idle(); tick();
        id_valid = 1'b1; id_instr = r_ins(5'd2, 5'd3, 5'd1, FN_ADD); tick();
        id_pc = 32'h200; id_instr = i_ins(OP_BEQ, 5'd1, 5'd0, 16'h0010); #1;
        n_tests++; if ({stall_if, pcsrc, flush_if} !== 3'b100) begin n_fail++; $display("FAIL bs_ex_stall: got %b want 100", {stall_if, pcsrc, flush_if}); end
        tick();
        mem_we = 1'b1; mem_addr = 5'd1; mem_alu = 32'd0; #1;
        n_tests++; if ({ex_valid, stall_if, pcsrc, flush_if} !== 4'b0011) begin n_fail++; $display("FAIL bs_ex_resolve: valid/stall/pcsrc/flush=%b want 0011", {ex_valid, stall_if, pcsrc, flush_if}); end
        n_tests++; if (pc_target !== 32'h240) begin n_fail++; $display("FAIL bs_target: got %h want 00000240", pc_target); end
        mem_alu = 32'd5; #1;
        n_tests++; if ({stall_if, pcsrc} !== 2'b00) begin n_fail++; $display("FAIL bs_not_taken: got %b want 00", {stall_if, pcsrc}); end
        tick();
        n_tests++; if ({ex_valid, ex_regwrite, ex_memwrite, ex_aluctl} !== {3'b100, ALU_SUB}) begin
            n_fail++; $display("FAIL bs_nt_loaded: valid/regwrite/memwrite=%b alu=%b want 100/0110", {ex_valid, ex_regwrite, ex_memwrite}, ex_aluctl);
        end
        idle(); tick();
        id_valid = 1'b1; id_instr = i_ins(OP_LW, 5'd0, 5'd1, 16'h0000); tick();
        id_pc = 32'h200; id_instr = i_ins(OP_BEQ, 5'd1, 5'd0, 16'h0010); #1;
        n_tests++; if ({stall_if, pcsrc} !== 2'b10) begin n_fail++; $display("FAIL bs_lw_stall1: got %b want 10", {stall_if, pcsrc}); end
        tick();
        mem_we = 1'b1; mem_memread = 1'b1; mem_addr = 5'd1; mem_alu = 32'h999; #1;
        n_tests++; if ({ex_valid, stall_if, pcsrc} !== 3'b010) begin n_fail++; $display("FAIL bs_lw_stall2: valid/stall/pcsrc=%b want 010", {ex_valid, stall_if, pcsrc}); end
        tick();
        mem_we = 1'b0; mem_memread = 1'b0; mem_addr = '0;
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd0; #1;
        n_tests++; if ({stall_if, pcsrc, flush_if, pc_target} !== {3'b011, 32'h240}) begin
            n_fail++; $display("FAIL bs_lw_resolve: flags=%b target=%h want 011/00000240", {stall_if, pcsrc, flush_if}, pc_target);
        end
        tick();
        idle();
    endtask

    task automatic test_jump();
        idle(); tick();
        id_valid = 1'b1; id_pc = 32'h10000004; id_instr = j_ins(26'h0000040); #1;
        n_tests++; if ({stall_if, pcsrc, flush_if, pc_target} !== {3'b011, 32'h10000100}) begin
            n_fail++; $display("FAIL j_target: flags=%b target=%h want 011/10000100", {stall_if, pcsrc, flush_if}, pc_target);
        end
        tick();
        n_tests++; if ({ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_memread, ex_alusrc, ex_regdst, ex_aluctl} !== {1'b1, 10'b0}) begin
            n_fail++; $display("FAIL j_ex_ctrl: got %b want 10000000000",
                               {ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_memread, ex_alusrc, ex_regdst, ex_aluctl});
        end
        id_pc = 32'h0; id_instr = i_ins(OP_BNE, 5'd2, 5'd0, 16'hFFFF); #1;
        n_tests++; if ({pcsrc, flush_if, pc_target} !== {2'b11, 32'hFFFFFFFC}) begin
            n_fail++; $display("FAIL bne_wrap: flags=%b target=%h want 11/fffffffc", {pcsrc, flush_if}, pc_target);
        end
        id_instr = i_ins(OP_BNE, 5'd0, 5'd0, 16'hFFFF); #1;
        n_tests++; if ({pcsrc, flush_if} !== 2'b00) begin n_fail++; $display("FAIL bne_not_taken: got %b want 00", {pcsrc, flush_if}); end
        id_valid = 1'b0; id_instr = j_ins(26'h40); #1;
        n_tests++; if ({stall_if, pcsrc, flush_if} !== 3'b000) begin n_fail++; $display("FAIL invalid_j: got %b want 000", {stall_if, pcsrc, flush_if}); end
        tick();
        n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL invalid_bubble: got %0b want 0", ex_valid); end
    endtask

    task automatic test_decode();
        logic [31:0] ins [9];
        logic [10:0] exp [9];
        ins[0] = r_ins(5'd8, 5'd9, 5'd10, FN_ADD);   exp[0] = {1'b1, 6'b100001, ALU_ADD};
        ins[1] = r_ins(5'd8, 5'd9, 5'd10, FN_SUB);   exp[1] = {1'b1, 6'b100001, ALU_SUB};
        ins[2] = r_ins(5'd8, 5'd9, 5'd10, FN_AND);   exp[2] = {1'b1, 6'b100001, ALU_AND};
        ins[3] = r_ins(5'd8, 5'd9, 5'd10, FN_OR);    exp[3] = {1'b1, 6'b100001, ALU_OR};
        ins[4] = r_ins(5'd8, 5'd9, 5'd10, FN_SLT);   exp[4] = {1'b1, 6'b100001, ALU_SLT};
        ins[5] = i_ins(OP_ADDI, 5'd8, 5'd10, 16'h5); exp[5] = {1'b1, 6'b100010, ALU_ADD};
        ins[6] = i_ins(OP_SW, 5'd8, 5'd9, 16'h4);    exp[6] = {1'b1, 6'b001010, ALU_ADD};
        ins[7] = i_ins(6'h3F, 5'd8, 5'd9, 16'h4);    exp[7] = {1'b1, 6'b000000, 4'b0000};
        ins[8] = r_ins(5'd8, 5'd9, 5'd10, 6'h3F);    exp[8] = {1'b1, 6'b000000, 4'b0000};
        idle(); tick();
        id_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            id_instr = ins[i]; tick();
            n_tests++;
            if ({ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_memread, ex_alusrc, ex_regdst, ex_aluctl} !== exp[i]) begin
                n_fail++; $display("FAIL decode_%0d: got %b want %b", i,
                                   {ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_memread, ex_alusrc, ex_regdst, ex_aluctl}, exp[i]);
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick(); tick();
        rst = 1'b0;
        test_reset();
        test_write_first();
        test_load_use();
        test_branch_fwd();
        test_branch_stall();
        test_jump();
        test_decode();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
